// File: rtl/arbitro_escrita_registradores.sv
// Register-file write-port arbiter: three one-entry holding buffers
// (ULA, memory load, I/O input) drained oldest-first into a single write port,
// with writes to the link register deferred while the jal link write is active.
module arbitro_escrita_registradores #(
    parameter int LARGURA_DADOS = 32,
    parameter int LARGURA_END   = 5,
    parameter int REG_LINK      = 31
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     valido_ula,
    input  logic [LARGURA_END-1:0]   destino_ula,
    input  logic [LARGURA_DADOS-1:0] dados_ula,
    output logic                     pronto_ula,
    input  logic                     valido_mem,
    input  logic [LARGURA_END-1:0]   destino_mem,
    input  logic [LARGURA_DADOS-1:0] dados_mem,
    output logic                     pronto_mem,
    input  logic                     valido_es,
    input  logic [LARGURA_END-1:0]   destino_es,
    input  logic [LARGURA_DADOS-1:0] dados_es,
    output logic                     pronto_es,
    input  logic                     jal,
    output logic                     escreveReg,
    output logic [LARGURA_END-1:0]   end_escrita,
    output logic [LARGURA_DADOS-1:0] dados_escrita,
    input  logic [LARGURA_END-1:0]   consulta_reg,
    output logic                     ocupado,
    output logic [1:0]               pendentes
);
    localparam int N = 3;

    // Buffer state: index 0 = ULA, 1 = memory, 2 = I/O
    logic [N-1:0]             ocup;
    logic [LARGURA_END-1:0]   dest [N];
    logic [LARGURA_DADOS-1:0] dado [N];
    logic [1:0]               idade [N];
    logic                     em_reset;

    logic [N-1:0]             valido;
    logic [N-1:0]             pronto;
    logic [N-1:0]             aceita;
    logic [LARGURA_END-1:0]   dest_in [N];
    logic [LARGURA_DADOS-1:0] dado_in [N];
    logic                     tem_cand;
    logic [1:0]               cand;
    logic                     concede;
    logic [1:0]               restantes;
    logic [1:0]               idade_nova [N];

    function automatic logic [1:0] conta_ocupados(input logic [N-1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // Gather the three request ports into indexable form
    always_comb begin
        valido     = {valido_es, valido_mem, valido_ula};
        dest_in[0] = destino_ula;
        dest_in[1] = destino_mem;
        dest_in[2] = destino_es;
        dado_in[0] = dados_ula;
        dado_in[1] = dados_mem;
        dado_in[2] = dados_es;
    end

    // Readiness comes from registers only; em_reset keeps it low while reset is seen
    assign pronto     = ~ocup & {N{~em_reset}};
    assign aceita     = valido & pronto;
    assign pronto_ula = pronto[0];
    assign pronto_mem = pronto[1];
    assign pronto_es  = pronto[2];
    assign pendentes  = conta_ocupados(ocup);

    // Candidate is the occupied entry at the head of the drain order (idade 0)
    always_comb begin
        tem_cand = 1'b0;
        cand     = 2'd0;
        for (int i = 0; i < N; i++) begin
            if (ocup[i] && idade[i] == 2'd0) begin
                tem_cand = 1'b1;
                cand     = 2'(i);
            end
        end
    end

    // A link-register write waits while jal owns the port; nothing commits during reset
    assign concede = tem_cand && !reset &&
                     !(jal && dest[cand] == LARGURA_END'(REG_LINK));

    // Write port drive and hazard lookup
    always_comb begin
        escreveReg    = concede;
        end_escrita   = '0;
        dados_escrita = '0;
        ocupado       = 1'b0;
        if (concede) begin
            end_escrita   = dest[cand];
            dados_escrita = dado[cand];
        end
        for (int i = 0; i < N; i++) begin
            if (ocup[i] && dest[i] == consulta_reg) ocupado = 1'b1;
        end
    end

    // New arrivals queue behind survivors, same-edge arrivals ordered ULA, mem, I/O
    always_comb begin
        restantes     = pendentes - {1'b0, concede};
        idade_nova[0] = restantes;
        idade_nova[1] = restantes + {1'b0, aceita[0]};
        idade_nova[2] = restantes + {1'b0, aceita[0]} + {1'b0, aceita[1]};
    end

    // Control state: occupancy, drain order and reset tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            ocup     <= '0;
            em_reset <= 1'b1;
            for (int i = 0; i < N; i++) idade[i] <= 2'd0;
        end else begin
            em_reset <= 1'b0;
            for (int i = 0; i < N; i++) begin
                if (aceita[i]) begin
                    ocup[i]  <= 1'b1;
                    idade[i] <= idade_nova[i];
                end else if (concede && cand == 2'(i)) begin
                    ocup[i]  <= 1'b0;
                    idade[i] <= 2'd0;
                end else if (concede && ocup[i] && idade[i] > idade[cand]) begin
                    idade[i] <= idade[i] - 2'd1;
                end
            end
        end
    end

    // Payload capture on accept; payload is only meaningful while occupied
    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (aceita[i]) begin
                dest[i] <= dest_in[i];
                dado[i] <= dado_in[i];
            end
        end
    end

endmodule

// File: tb/tb_arbitro_escrita_registradores.sv
// Bench for arbitro_escrita_registradores: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a queue model.
module tb_arbitro_escrita_registradores;
    logic        clock = 1'b0;
    logic        reset;
    logic        valido_ula, valido_mem, valido_es;
    logic [4:0]  destino_ula, destino_mem, destino_es;
    logic [31:0] dados_ula, dados_mem, dados_es;
    logic        pronto_ula, pronto_mem, pronto_es;
    logic        jal;
    logic        escreveReg;
    logic [4:0]  end_escrita;
    logic [31:0] dados_escrita;
    logic [4:0]  consulta_reg;
    logic        ocupado;
    logic [1:0]  pendentes;

    int checks = 0;
    int errors = 0;

    arbitro_escrita_registradores dut (
        .clock(clock), .reset(reset),
        .valido_ula(valido_ula), .destino_ula(destino_ula), .dados_ula(dados_ula), .pronto_ula(pronto_ula),
        .valido_mem(valido_mem), .destino_mem(destino_mem), .dados_mem(dados_mem), .pronto_mem(pronto_mem),
        .valido_es(valido_es), .destino_es(destino_es), .dados_es(dados_es), .pronto_es(pronto_es),
        .jal(jal), .escreveReg(escreveReg), .end_escrita(end_escrita), .dados_escrita(dados_escrita),
        .consulta_reg(consulta_reg), .ocupado(ocupado), .pendentes(pendentes)
    );

    always #5 clock = ~clock;

    // Reference model: a FIFO of pending writes in acceptance order
    typedef struct packed {
        logic [1:0]  src;
        logic [4:0]  d;
        logic [31:0] v;
    } ent_t;

    ent_t        fila[$];
    bit          rst_prev = 1'b1;
    bit          armado = 1'b0;
    logic [31:0] rf_model [32];
    logic [31:0] rf_dut [32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit tem_src(input int s);
        foreach (fila[k]) if (fila[k].src == 2'(s)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit pode_conceder();
        return (fila.size() > 0) && !(fila[0].d == 5'd31 && jal);
    endfunction

    // Model update on each rising edge
    always @(posedge clock) begin
        bit pr [3];
        if (reset) begin
            fila.delete();
            rst_prev = 1'b1;
            armado   = 1'b1;
        end else begin
            for (int s = 0; s < 3; s++) pr[s] = !rst_prev && !tem_src(s);
            if (pode_conceder()) begin
                rf_model[fila[0].d] = fila[0].v;
                void'(fila.pop_front());
            end
            if (valido_ula && pr[0]) fila.push_back({2'd0, destino_ula, dados_ula});
            if (valido_mem && pr[1]) fila.push_back({2'd1, destino_mem, dados_mem});
            if (valido_es  && pr[2]) fila.push_back({2'd2, destino_es,  dados_es});
            rst_prev = 1'b0;
        end
    end

    // Every-cycle comparison of DUT outputs against the model, mid-cycle
    always @(negedge clock) begin
        bit          we;
        bit          oc;
        logic [4:0]  ea;
        logic [31:0] ed;
        if (escreveReg === 1'b1) rf_dut[end_escrita] = dados_escrita;
        if (armado) begin
            we = !reset && pode_conceder();
            ea = we ? fila[0].d : 5'd0;
            ed = we ? fila[0].v : 32'd0;
            oc = 1'b0;
            foreach (fila[k]) if (fila[k].d == consulta_reg) oc = 1'b1;
            chk("escreveReg", 32'(escreveReg), 32'(we));
            chk("end_escrita", 32'(end_escrita), 32'(ea));
            chk("dados_escrita", dados_escrita, ed);
            chk("pendentes", 32'(pendentes), 32'(fila.size()));
            chk("ocupado", 32'(ocupado), 32'(oc));
            if (!(rst_prev && !reset)) begin
                chk("pronto_ula", 32'(pronto_ula), 32'(!rst_prev && !tem_src(0)));
                chk("pronto_mem", 32'(pronto_mem), 32'(!rst_prev && !tem_src(1)));
                chk("pronto_es",  32'(pronto_es),  32'(!rst_prev && !tem_src(2)));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic meio();
        @(negedge clock);
    endtask

    task automatic limpa_req();
        valido_ula = 1'b0; valido_mem = 1'b0; valido_es = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog at t=%0t: actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit prev_reset;
        for (int r = 0; r < 32; r++) begin
            rf_model[r] = 32'hDEAD_BEEF;
            rf_dut[r]   = 32'hDEAD_BEEF;
        end
        reset = 1'b1; jal = 1'b0; consulta_reg = 5'd0;
        limpa_req();
        destino_ula = 5'd0; destino_mem = 5'd0; destino_es = 5'd0;
        dados_ula = 32'd0; dados_mem = 32'd0; dados_es = 32'd0;

        // Reset held: pronto low, nothing pending
        tick(); tick();
        meio();
        chk("rst_pronto_ula", 32'(pronto_ula), 32'd0);
        chk("rst_escreveReg", 32'(escreveReg), 32'd0);
        chk("rst_pendentes", 32'(pendentes), 32'd0);

        // First cycle after release
        tick(); reset = 1'b0;
        meio();
        chk("pos_rst_we", 32'(escreveReg), 32'd0);
        chk("pos_rst_end", 32'(end_escrita), 32'd0);
        chk("pos_rst_dados", dados_escrita, 32'd0);
        chk("pos_rst_ocupado", 32'(ocupado), 32'd0);

        // Single write
        tick();
        valido_ula = 1'b1; destino_ula = 5'd5; dados_ula = 32'h0000_00AA;
        meio();
        chk("idle_pronto_ula", 32'(pronto_ula), 32'd1);
        chk("idle_pronto_mem", 32'(pronto_mem), 32'd1);
        chk("idle_pronto_es",  32'(pronto_es),  32'd1);
        tick(); limpa_req();
        meio();
        chk("single_we", 32'(escreveReg), 32'd1);
        chk("single_end", 32'(end_escrita), 32'd5);
        chk("single_dados", dados_escrita, 32'hAA);
        chk("single_pronto_busy", 32'(pronto_ula), 32'd0);
        tick();
        meio();
        chk("single_pronto_back", 32'(pronto_ula), 32'd1);
        chk("single_we_off", 32'(escreveReg), 32'd0);

        // Simultaneous arrivals drain ULA, mem, I/O
        valido_ula = 1'b1; destino_ula = 5'd3; dados_ula = 32'h11;
        valido_mem = 1'b1; destino_mem = 5'd4; dados_mem = 32'h22;
        valido_es  = 1'b1; destino_es  = 5'd5; dados_es  = 32'h33;
        tick(); limpa_req();
        meio();
        chk("sim_model_fila", 32'(fila.size()), 32'd3);
        chk("sim_pend3", 32'(pendentes), 32'd3);
        chk("sim_w1", {19'd0, end_escrita, dados_escrita[7:0]}, {19'd0, 5'd3, 8'h11});
        tick(); meio();
        chk("sim_pend2", 32'(pendentes), 32'd2);
        chk("sim_w2", {19'd0, end_escrita, dados_escrita[7:0]}, {19'd0, 5'd4, 8'h22});
        tick(); meio();
        chk("sim_pend1", 32'(pendentes), 32'd1);
        chk("sim_w3", {19'd0, end_escrita, dados_escrita[7:0]}, {19'd0, 5'd5, 8'h33});
        tick(); meio();
        chk("sim_pend0", 32'(pendentes), 32'd0);
        chk("sim_we_off", 32'(escreveReg), 32'd0);

        // Same register from two requesters keeps acceptance order
        valido_mem = 1'b1; destino_mem = 5'd7; dados_mem = 32'h1;
        tick(); limpa_req();
        valido_ula = 1'b1; destino_ula = 5'd7; dados_ula = 32'h2;
        meio();
        chk("ord_first", dados_escrita, 32'h1);
        tick(); limpa_req();
        meio();
        chk("ord_second", dados_escrita, 32'h2);
        chk("ord_end", 32'(end_escrita), 32'd7);
        tick(); meio();
        chk("ord_final_dut", rf_dut[7], 32'h2);
        chk("ord_final_model", rf_model[7], 32'h2);

        // jal holds a pending link-register write
        valido_ula = 1'b1; destino_ula = 5'd31; dados_ula = 32'h40;
        tick(); limpa_req(); jal = 1'b1; consulta_reg = 5'd31;
        meio();
        chk("jal_hold1_we", 32'(escreveReg), 32'd0);
        chk("jal_hold1_oc", 32'(ocupado), 32'd1);
        tick(); meio();
        chk("jal_hold2_we", 32'(escreveReg), 32'd0);
        chk("jal_hold2_oc", 32'(ocupado), 32'd1);
        tick(); jal = 1'b0;
        meio();
        chk("jal_rel_we", 32'(escreveReg), 32'd1);
        chk("jal_rel_end", 32'(end_escrita), 32'd31);
        chk("jal_rel_dados", dados_escrita, 32'h40);
        chk("jal_rel_oc", 32'(ocupado), 32'd1);
        tick(); meio();
        chk("jal_after_oc", 32'(ocupado), 32'd0);

        // Hazard query
        valido_es = 1'b1; destino_es = 5'd9; dados_es = 32'h9; consulta_reg = 5'd9;
        tick(); limpa_req();
        meio();
        chk("haz_grant_oc", 32'(ocupado), 32'd1);
        chk("haz_grant_we", 32'(escreveReg), 32'd1);
        tick(); meio();
        chk("haz_after_oc", 32'(ocupado), 32'd0);
        valido_es = 1'b1; consulta_reg = 5'd10;
        tick(); limpa_req();
        meio();
        chk("haz_other_oc", 32'(ocupado), 32'd0);

        // Reset after the first grant of a full drain
        tick();
        valido_ula = 1'b1; destino_ula = 5'd1; dados_ula = 32'hA1;
        valido_mem = 1'b1; destino_mem = 5'd2; dados_mem = 32'hA2;
        valido_es  = 1'b1; destino_es  = 5'd6; dados_es  = 32'hA6;
        tick(); limpa_req();
        meio();
        chk("rmd_first_end", 32'(end_escrita), 32'd1);
        tick(); reset = 1'b1;
        meio();
        chk("rmd_rst_we", 32'(escreveReg), 32'd0);
        tick(); reset = 1'b0;
        meio();
        chk("rmd_post_we", 32'(escreveReg), 32'd0);
        chk("rmd_post_pend", 32'(pendentes), 32'd0);
        tick(); meio();
        chk("rmd_pronto", {29'd0, pronto_ula, pronto_mem, pronto_es}, 32'd7);
        chk("rmd_r6_untouched", rf_dut[6], 32'hDEAD_BEEF);

        // Randomized traffic, reset occasionally
        prev_reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (prev_reset) begin
                reset = 1'b0;
                limpa_req();
            end else begin
                reset      = ($urandom_range(0, 59) == 0);
                valido_ula = 1'($urandom_range(0, 1));
                valido_mem = 1'($urandom_range(0, 1));
                valido_es  = 1'($urandom_range(0, 1));
            end
            destino_ula  = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            destino_mem  = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            destino_es   = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            dados_ula    = $urandom;
            dados_mem    = $urandom;
            dados_es     = $urandom;
            jal          = ($urandom_range(0, 3) == 0);
            consulta_reg = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            prev_reset   = reset;
        end
        tick(); reset = 1'b0; limpa_req(); jal = 1'b0;
        tick(); tick(); tick(); tick();
        meio();
        for (int r = 0; r < 32; r++) chk($sformatf("regfile_r%0d", r), rf_dut[r], rf_model[r]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/arbitro_escrita_registradores.md
Name: arbitro_escrita_registradores

Overview:
Write-port arbiter for the 32x32 register file. Three producers (ULA result, memory load, I/O input) each hand off one pending write through a valid/ready handshake into a one-entry holding buffer. The arbiter drains the buffers oldest-first into the register file's single write port and defers any write to the link register while the jal link write is active. It also reports whether a given register has a write still pending, so the control unit can stall dependent reads.

Parameters:
LARGURA_DADOS, 32, data width of every write.
LARGURA_END, 5, register index width.
REG_LINK, 31, register written by the jal link path.

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
valido_ula  in  1  ULA write request
destino_ula  in  5  ULA destination register
dados_ula  in  32  ULA write data
pronto_ula  out  1  ULA buffer can accept
valido_mem  in  1  memory-load write request
destino_mem  in  5  memory-load destination register
dados_mem  in  32  memory-load write data
pronto_mem  out  1  memory buffer can accept
valido_es  in  1  I/O-input write request
destino_es  in  5  I/O destination register
dados_es  in  32  I/O write data
pronto_es  out  1  I/O buffer can accept
jal  in  1  link write to REG_LINK occurring this cycle
escreveReg  out  1  write enable to register file
end_escrita  out  5  write address to register file
dados_escrita  out  32  write data to register file
consulta_reg  in  5  register index being checked for a hazard
ocupado  out  1  a buffered write targets consulta_reg
pendentes  out  2  number of occupied buffers, 0..3

Behaviour:
- Reset: synchronous, active-high. All buffers are cleared, all ages are 0, and all pronto_* are held 0 while reset is high. After reset drops, pronto_*=1, escreveReg=0, end_escrita=0, dados_escrita=0, ocupado=0, pendentes=0.
- Buffers: one per requester, holding {ocupado bit, destino, dados, idade[1:0]}.
- Readiness: pronto_x = buffer x empty. It is derived from registered state only and has no combinational path from any input.
- Accept: valido_x && pronto_x at edge N loads buffer x. valido_x while pronto_x=0 is ignored; the requester must hold it.
- Per-requester throughput: at most one accept every 2 cycles, because the buffer frees at the grant edge and pronto rises the cycle after.
- Age: idade = position in the drain order, 0 = oldest. A new entry gets idade = number of entries that remain occupied after this edge's grant. Entries accepted on the same edge are ordered ULA < mem < es.
- Age on grant: every remaining entry whose idade is greater than the granted entry's idade decrements by 1.
- Grant: in any cycle with an occupied buffer, the entry with idade 0 is the candidate.
  - If the candidate's destino == REG_LINK and jal=1, there is no grant: escreveReg=0 and the candidate is retained.
  - Otherwise escreveReg=1, with end_escrita and dados_escrita taken from the candidate. These are combinational from registered state. The buffer clears at the end-of-cycle edge, and the register file captures the data on that same edge.
- Latency: accept edge N, then escreveReg high in cycle N+1 at the earliest.
- Ordering: writes to the same register always commit in acceptance order, with no reordering across requesters.
- Idle outputs: with no grant, end_escrita and dados_escrita drive 0.
- Grant rate: one write per cycle maximum. With all three buffers full, the drain takes 3 consecutive cycles unless blocked by jal.
- Accept and grant on the same edge for different buffers are both legal. A buffer granted at edge N cannot be reloaded at edge N, since its pronto was 0.
- ocupado: OR over occupied buffers of (destino == consulta_reg). It is combinational and includes the entry being granted in the current cycle.
- pendentes: population count of occupied buffers, registered-state based.
- Register 0: receives no special treatment; writes to it are forwarded unchanged.
- Reset mid-operation: buffered writes are discarded, and escreveReg is 0 in the reset cycle and the cycle after.

Test Plan:
- Single write: after reset, valido_ula=1, destino_ula=5, dados_ula=0x0000_00AA for 1 cycle -> next cycle escreveReg=1, end_escrita=5, dados_escrita=0xAA; pronto_ula returns to 1 one cycle later.
- Simultaneous arrivals: ULA(r3,0x11), mem(r4,0x22), es(r5,0x33) on the same edge -> pendentes=3, then writes in consecutive cycles r3/0x11, r4/0x22, r5/0x33; pendentes steps 3,2,1,0.
- Ordering: mem(r7,0x1) accepted at edge 0, ULA(r7,0x2) accepted at edge 1 -> r7 written with 0x1 first, then 0x2; the final value is 0x2.
- jal conflict: buffered ULA(r31,0x40) with jal=1 for 2 cycles -> escreveReg=0 for both cycles; the write of r31=0x40 occurs in the first cycle with jal=0, and ocupado=1 with consulta_reg=31 throughout the hold.
- Hazard query: es(r9,0x9) buffered, consulta_reg=9 -> ocupado=1 until the grant cycle inclusive, then 0; consulta_reg=10 -> ocupado=0 throughout.
- Reset mid-drain: 3 entries buffered, reset=1 for 1 cycle after the first grant -> no further writes, pendentes=0, pronto_*=1 the cycle after reset drops.
